mips_decode_stage: RTL

- Instruction-decode stage directly upstream of mips_registers.
- Accepts a fetched instruction and PC over a valid/ready handshake, then decodes the fields and control signals.
- Presents them from a one-entry registered output slot. read_reg_1/read_reg_2/write_reg/signal_reg_write feed the register file; the remaining controls go to the execute stage.
- Enforces a one-cycle load-use interlock.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/mips_ctrl_decode.sv | 133 +++++++++++++
 rtl/mips_decode_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct encodings, alu_op codes and decoded-bundle type for the decode stage
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6
    } alu_op_e;

    typedef struct packed {
        logic [4:0]  read_reg_1;
        logic [4:0]  read_reg_2;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic [31:0] imm_ext;
        logic [4:0]  shamt;
        alu_op_e     alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        branch_ne;
        logic        jump;
    } decoded_t;

    // andi/ori take a zero-extended immediate, everything else sign-extends
    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zero_ext);
        return zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational instruction decoder: instr to control bundle and operand usage
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec,
    output logic        rs_used,
    output logic        rt_used,
    output logic        illegal
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic        zero_ext;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign sh    = instr[10:6];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];

    // decode op/funct into controls; unsupported encodings collapse to an all-zero bubble
    always_comb begin
        dec      = '0;
        rs_used  = 1'b0;
        rt_used  = 1'b0;
        illegal  = 1'b0;
        zero_ext = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec.write_reg = rd;
                dec.reg_write = 1'b1;
                rs_used       = 1'b1;
                rt_used       = 1'b1;
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLL: begin
                        dec.alu_op = ALU_SLL;
                        rs_used    = 1'b0;
                    end
                    FN_SRL: begin
                        dec.alu_op = ALU_SRL;
                        rs_used    = 1'b0;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = 1'b1;
                dec.write_reg = rt;
                dec.reg_write = 1'b1;
                rs_used       = 1'b1;
            end
            OP_ANDI: begin
                dec.alu_op    = ALU_AND;
                dec.alu_src   = 1'b1;
                dec.write_reg = rt;
                dec.reg_write = 1'b1;
                rs_used       = 1'b1;
                zero_ext      = 1'b1;
            end
            OP_ORI: begin
                dec.alu_op    = ALU_OR;
                dec.alu_src   = 1'b1;
                dec.write_reg = rt;
                dec.reg_write = 1'b1;
                rs_used       = 1'b1;
                zero_ext      = 1'b1;
            end
            OP_LW: begin
                dec.alu_op     = ALU_ADD;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.write_reg  = rt;
                dec.reg_write  = 1'b1;
                rs_used        = 1'b1;
            end
            OP_SW: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                rs_used       = 1'b1;
                rt_used       = 1'b1;
            end
            OP_BEQ: begin
                dec.alu_op = ALU_SUB;
                dec.branch = 1'b1;
                rs_used    = 1'b1;
                rt_used    = 1'b1;
            end
            OP_BNE: begin
                dec.alu_op    = ALU_SUB;
                dec.branch    = 1'b1;
                dec.branch_ne = 1'b1;
                rs_used       = 1'b1;
                rt_used       = 1'b1;
            end
            OP_J: begin
                dec.jump = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            dec     = '0;
            rs_used = 1'b0;
            rt_used = 1'b0;
        end else begin
            dec.read_reg_1 = rs;
            dec.read_reg_2 = rt;
            dec.imm_ext    = ext_imm(imm, zero_ext);
            dec.shamt      = sh;
            // $0 is hardwired, so a write to it is dropped here
            if (dec.write_reg == 5'd0) begin
                dec.reg_write = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mips_decode_stage.sv
// rtl/mips_decode_stage.sv - decode stage with one-entry output slot and load-use interlock; option MIPS_DECODE_ILLEGAL_EN
module mips_decode_stage
    import mips_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      read_reg_1,
    output logic [4:0]      read_reg_2,
    output logic [4:0]      write_reg,
    output logic            signal_reg_write,
    output logic [31:0]     imm_ext,
    output logic [4:0]      shamt,
    output logic [3:0]      alu_op,
    output logic            alu_src,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            branch,
    output logic            branch_ne,
    output logic            jump,
    output logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] pc_out
`ifdef MIPS_DECODE_ILLEGAL_EN
    ,
    output logic            illegal,
    output logic            illegal_sticky
`endif
);

    decoded_t        dec;
    logic            dec_rs_used;
    logic            dec_rt_used;
    logic            dec_illegal;

    decoded_t        slot;
    logic            slot_valid;
    logic [PC_W-1:0] slot_pc;
    logic [PC_W-1:0] slot_jt;
    logic [4:0]      shadow_rt;

    logic [4:0]      in_rs;
    logic [4:0]      in_rt;
    logic            lw_in_slot;
    logic            hazard;
    logic            accept;
    logic            drain;
    logic [PC_W-1:0] pc_plus4;

    mips_ctrl_decode u_ctrl (
        .instr   (instr),
        .dec     (dec),
        .rs_used (dec_rs_used),
        .rt_used (dec_rt_used),
        .illegal (dec_illegal)
    );

    assign in_rs      = instr[25:21];
    assign in_rt      = instr[20:16];
    assign lw_in_slot = slot_valid && slot.mem_read;
    assign pc_plus4   = pc_in + PC_W'(4);

    // a used operand collides with a load still in the slot or one that left last cycle
    always_comb begin
        hazard = 1'b0;
        if (dec_rs_used && in_rs != 5'd0) begin
            if ((lw_in_slot && in_rs == slot.read_reg_2) || in_rs == shadow_rt) begin
                hazard = 1'b1;
            end
        end
        if (dec_rt_used && in_rt != 5'd0) begin
            if ((lw_in_slot && in_rt == slot.read_reg_2) || in_rt == shadow_rt) begin
                hazard = 1'b1;
            end
        end
    end

    assign in_ready = (!slot_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign drain    = slot_valid && out_ready;

    // output slot: load on accept (also when draining), empty on drain alone, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot       <= '0;
            slot_valid <= 1'b0;
            slot_pc    <= RESET_PC;
            slot_jt    <= '0;
        end else if (accept) begin
            slot       <= dec;
            slot_valid <= 1'b1;
            slot_pc    <= pc_in;
            slot_jt    <= {pc_plus4[PC_W-1:28], instr[25:0], 2'b00};
        end else if (drain) begin
            slot_valid <= 1'b0;
        end
    end

    // remembers the rt of a load for the one cycle after it leaves; 0 means empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_rt <= 5'd0;
        end else if (drain && slot.mem_read) begin
            shadow_rt <= slot.read_reg_2;
        end else begin
            shadow_rt <= 5'd0;
        end
    end

`ifdef MIPS_DECODE_ILLEGAL_EN
    logic slot_illegal;

    // illegal flag travels with the slot; sticky flag latches once one leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_illegal   <= 1'b0;
            illegal_sticky <= 1'b0;
        end else begin
            if (accept) begin
                slot_illegal <= dec_illegal;
            end
            if (drain && slot_illegal) begin
                illegal_sticky <= 1'b1;
            end
        end
    end

    assign illegal = slot_illegal;
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
`endif

    assign out_valid        = slot_valid;
    assign read_reg_1       = slot.read_reg_1;
    assign read_reg_2       = slot.read_reg_2;
    assign write_reg        = slot.write_reg;
    assign signal_reg_write = slot.reg_write;
    assign imm_ext          = slot.imm_ext;
    assign shamt            = slot.shamt;
    assign alu_op           = slot.alu_op;
    assign alu_src          = slot.alu_src;
    assign mem_read         = slot.mem_read;
    assign mem_write        = slot.mem_write;
    assign mem_to_reg       = slot.mem_to_reg;
    assign branch           = slot.branch;
    assign branch_ne        = slot.branch_ne;
    assign jump             = slot.jump;
    assign jump_target      = slot_jt;
    assign pc_out           = slot_pc;

endmodule
